// File: rtl/nbit_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nbit_mux_pkg
// Brief    : Shared constants, output-register state encoding and the
//            index-width helper for the round-robin channel mux.
// Revision : 1.0  initial release
// ============================================================================
package nbit_mux_pkg;

    localparam int c_XFER_CNT_W = 16;

    localparam logic c_ST_EMPTY = 1'b0;
    localparam logic c_ST_FULL  = 1'b1;

    // A single-channel index still needs one bit of select.
    function automatic int idx_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin grant. Searches upward from ptr, wrapping, and
//            returns a one-hot grant plus the pointer to use afterwards.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import nbit_mux_pkg::*;
#(
    parameter int CH = 4
) (
    input  logic [CH-1:0]              req,
    input  logic [idx_width(CH)-1:0]   ptr,
    input  logic                       en,
    output logic [CH-1:0]              grant,
    output logic [idx_width(CH)-1:0]   grant_idx,
    output logic [idx_width(CH)-1:0]   next_ptr
);

    localparam int PW = idx_width(CH);

    int   w_idx;
    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        next_ptr  = ptr;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int off = 0; off < CH; off++) begin
            w_idx = (int'(ptr) + off) % CH;
            if (en && !w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = PW'(w_idx);
                // The winner moves to the back of the queue.
                next_ptr     = PW'((w_idx + 1) % CH);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/n_channel_rr_mux.sv
`default_nettype none
// ============================================================================
// Module   : n_channel_rr_mux
// Brief    : CH-input round-robin mux into a one-entry registered output.
//            Define RR_MUX_XFER_COUNT_EN to add the xfer_count handshake
//            counter output.
// Revision : 1.0  initial release
// ============================================================================
module n_channel_rr_mux
    import nbit_mux_pkg::*;
#(
    parameter int N  = 5,
    parameter int CH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH*N-1:0]            in_data,
    input  logic [CH-1:0]              in_valid,
    output logic [CH-1:0]              in_ready,
    output logic [N-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [idx_width(CH)-1:0]   out_sel
`ifdef RR_MUX_XFER_COUNT_EN
    ,
    output logic [c_XFER_CNT_W-1:0]    xfer_count
`endif
);

    localparam int PW = idx_width(CH);

    logic          r_state;
    logic          w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic [PW-1:0] w_gnt_idx;
    logic [CH-1:0] w_grant;
    logic [N-1:0]  w_sel_data;
    logic          w_load;
    logic          w_xfer;

    assign w_load    = (r_state == c_ST_EMPTY) || out_ready;
    assign out_valid = (r_state == c_ST_FULL);

    // Gating with rst keeps in_ready low throughout reset, not just after an edge.
    rr_arbiter #(
        .CH        (CH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .en        (w_load && !rst),
        .grant     (w_grant),
        .grant_idx (w_gnt_idx),
        .next_ptr  (w_next_ptr)
    );

    assign in_ready = w_grant;
    assign w_xfer   = |w_grant;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | in_data[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_xfer) w_state_nxt = c_ST_FULL;
            c_ST_FULL:  if (out_ready && !w_xfer) w_state_nxt = c_ST_EMPTY;
            default:    w_state_nxt = c_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
            r_ptr    <= '0;
        end else if (w_xfer) begin
            out_data <= w_sel_data;
            out_sel  <= w_gnt_idx;
            r_ptr    <= w_next_ptr;
        end
    end

`ifdef RR_MUX_XFER_COUNT_EN
    logic [c_XFER_CNT_W-1:0] r_xfer_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            r_xfer_count <= r_xfer_count + 1'b1;
        end
    end

    assign xfer_count = r_xfer_count;
`else
    // No handshake counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_n_channel_rr_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_n_channel_rr_mux
// Brief    : Directed plus random scoreboard bench for n_channel_rr_mux
//            (N=5, CH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_n_channel_rr_mux;

    localparam int N  = 5;
    localparam int CH = 4;
    localparam int SW = 2;

    logic              clk;
    logic              rst;
    logic [CH*N-1:0]   in_data;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic [N-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_sel;
`ifdef RR_MUX_XFER_COUNT_EN
    logic [15:0]       xfer_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [N+SW-1:0] sb_q[$];
    logic [N+SW-1:0] m_last;
    int              m_ptr;
    logic            m_valid;
    int              m_cnt;

    n_channel_rr_mux #(
        .N          (N),
        .CH         (CH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel)
`ifdef RR_MUX_XFER_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive, check in_ready, let the edge happen, check the output register.
    task automatic step(input logic [CH-1:0] v, input logic ordy);
        logic [CH-1:0]   exp_gnt;
        logic [N+SW-1:0] e;
        logic            ld;
        int              k;
        int              j;
        in_valid  = v;
        out_ready = ordy;
        #1;
        ld      = !m_valid || ordy;
        exp_gnt = '0;
        k       = -1;
        if (ld) begin
            for (int o = 0; o < CH; o++) begin
                j = (m_ptr + o) % CH;
                if (k < 0 && v[j]) k = j;
            end
        end
        if (k >= 0) begin
            exp_gnt[k] = 1'b1;
            sb_q.push_back({in_data[k*N +: N], SW'(k)});
            m_ptr = (k + 1) % CH;
        end
        if (m_valid && ordy) m_cnt++;
        check("in_ready", 32'(in_ready), 32'(exp_gnt));
        if (ld) m_valid = (k >= 0);
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (k >= 0) begin
            e      = sb_q.pop_front();
            m_last = e;
        end
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_last[N+SW-1:SW]));
            check("out_sel", 32'(out_sel), 32'(m_last[SW-1:0]));
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_last  = '0;
        sb_q.delete();
    endtask

    initial begin
        // ch3=11100 ch2=11011 ch1=10101 ch0=01010
        in_data   = {5'b11100, 5'b11011, 5'b10101, 5'b01010};
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        rst       = 1'b1;
        model_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(4'b0100, 1'b1);
        check("single_sel", 32'(out_sel), 32'd2);
        check("single_data", 32'(out_data), 32'b11011);

        // Asynchronous reset between edges while a word is held.
        in_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_sel", 32'(out_sel), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1);
            check("rr_seq", 32'(out_sel), 32'(i % CH));
        end

        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0);
            check("bp_hold_sel", 32'(out_sel), 32'd0);
            check("bp_hold_data", 32'(out_data), 32'b01010);
        end
        step(4'b1111, 1'b1);
        check("bp_release_sel", 32'(out_sel), 32'd1);

        step(4'b1111, 1'b1);
        step(4'b0010, 1'b1);
        check("wrap_sel", 32'(out_sel), 32'd1);
        step(4'b1111, 1'b1);
        check("wrap_ptr", 32'(out_sel), 32'd2);
        step(4'b0000, 1'b1);
        check("drain", 32'(out_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

`ifdef RR_MUX_XFER_COUNT_EN
        check("cnt_running", 32'(xfer_count), 32'(m_cnt[15:0]));
        in_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) step(4'b1111, 1'b1);
        check("cnt_five", 32'(xfer_count), 32'd5);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        while (m_cnt < 65535) begin
            @(posedge clk);
            m_cnt++;
        end
        #1;
        check("cnt_ffff", 32'(xfer_count), 32'hFFFF);
        @(posedge clk);
        #1;
        check("cnt_wrap", 32'(xfer_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/n_channel_rr_mux.md
N_CHANNEL_RR_MUX -- requirements
Module: n_channel_rr_mux

Interface
REQ-001 SHALL have parameter N, default 5, data width per channel in bits (N >= 1).
REQ-002 SHALL have parameter CH, default 4, number of input channels (2 <= CH <= 16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  CH*N  channel i data in bits [i*N+N-1 : i*N].
REQ-006 SHALL have port in_valid  input  CH  bit i set = channel i offers a word.
REQ-007 SHALL have port in_ready  output  CH  bit i set = channel i word accepted this cycle.
REQ-008 SHALL have port out_data  output  N  registered selected word.
REQ-009 SHALL have port out_valid  output  1  out_data holds an undelivered word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 SHALL have port out_sel  output  max(1,$clog2(CH))  channel index that supplied out_data.

Function
REQ-012 SHALL hold a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define load = !out_valid || out_ready; a new word is captured only when load=1.
REQ-014 SHALL grant, when load=1 and any in_valid set, exactly one channel: the first set in_valid bit searching upward from pointer ptr, wrapping CH-1 -> 0.
REQ-015 SHALL drive in_ready[i]=1 only for the granted channel when load=1; all other bits 0; in_ready combinational from in_valid, ptr, out_valid, out_ready.
REQ-016 SHALL, on a transfer from channel k, capture in_data[k] into out_data, k into out_sel, set out_valid=1 next cycle (latency 1 cycle).
REQ-017 SHALL, on a transfer from channel k, update ptr to k+1, wrapping CH-1 -> 0; ptr unchanged otherwise.
REQ-018 SHALL transition FULL -> EMPTY when out_ready=1 and no in_valid set; FULL -> FULL with new word when out_ready=1 and a grant occurs (full throughput, one word per cycle).
REQ-019 SHALL hold out_data, out_sel, out_valid stable while out_valid=1 and out_ready=0; in_ready all 0 then.
REQ-020 SHALL ignore in_data of channels whose in_valid=0; no channel is granted twice before every other requesting channel has been granted once (starvation-free).

Reset
REQ-021 SHALL on rst=1 immediately force out_valid=0, out_data=0, out_sel=0, ptr=0, and in_ready=0, regardless of clk.
REQ-022 SHALL, if rst asserts mid-transfer, discard the in-flight word; first grant after release uses ptr=0.

Configuration
REQ-023 SHALL, with macro RR_MUX_XFER_COUNT_EN defined, add output xfer_count (16 bits): count of out_valid&&out_ready handshakes, wraps 0xFFFF -> 0, reset to 0.
REQ-024 SHALL, without RR_MUX_XFER_COUNT_EN, have no xfer_count port and no counter logic; all other behaviour identical.

Structure
REQ-025 SHALL take the index-width helper (max(1,$clog2(CH))) and the counter width constant 16 from shared package nbit_mux_pkg.
REQ-026 SHALL implement grant and pointer logic in sub-module rr_arbiter (parameter CH; inputs req, ptr, en; output one-hot grant); datapath selection and output register remain in n_channel_rr_mux.

Verification (N=5, CH=4)
REQ-027 Reset: rst=1 with all in_valid=1 -> out_valid=0, in_ready=0000, out_data=00000 with no clock edge.
REQ-028 Single requester: in_valid=0100, in_data ch2=11011, out_ready=1 -> in_ready=0100; next cycle out_data=11011, out_sel=2, out_valid=1.
REQ-029 Round-robin: in_valid=1111 held, data a=01010 b=10101 c=11011 d=11100, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-030 Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000, out_data/out_sel unchanged; on out_ready=1 next channel after out_sel granted.
REQ-031 Wrap/skip: ptr=3, in_valid=0010 -> channel 1 granted, ptr becomes 2.
REQ-032 With RR_MUX_XFER_COUNT_EN: 5 handshakes -> xfer_count=5; preload count to 0xFFFF via 65535 handshakes then one more -> 0.
